// File: rtl/mul8_seq_ctrl.sv
// mul8_seq_ctrl: 8x8 unsigned multiply sequenced over one shared 4x4 array
// multiplier, valid/ready in (a,b) and out (product).
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     operand handshake, a/b 8-bit operands
//   out_valid/out_ready   product handshake, product 16-bit result
//   mul_m/mul_q/mul_p     operand pins and 8-bit result of the shared 4x4
//   busy                  high while partial-product steps run
module mul8_seq_ctrl #(
   parameter bit SKIP_ZERO = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] product,
   output logic [3:0]  mul_m,
   output logic [3:0]  mul_q,
   input  logic [7:0]  mul_p,
   output logic        busy
);

   typedef enum logic [2:0] {
      S_IDLE, S_PP0, S_PP1, S_PP2, S_PP3, S_DONE
   } state_t;

   state_t      r_state;
   logic [7:0]  r_a;
   logic [7:0]  r_b;
   logic [15:0] r_acc;

   state_t      w_nxt;
   logic [7:0]  w_nxt_a;
   logic [7:0]  w_nxt_b;
   logic [15:0] w_nxt_acc;
   logic [15:0] w_pp;
   logic        w_accept;
   logic [3:0]  w_live_cur;

   // Bit i set when step PPi must run for operands x,y.
   function automatic logic [3:0] live(input logic [7:0] x,
                                       input logic [7:0] y);
      logic [3:0] l;
      l[0] = (|x[3:0]) & (|y[3:0]);
      l[1] = (|x[7:4]) & (|y[3:0]);
      l[2] = (|x[3:0]) & (|y[7:4]);
      l[3] = (|x[7:4]) & (|y[7:4]);
      return SKIP_ZERO ? l : 4'hF;
   endfunction

   // Lowest live step, or DONE when nothing is left to do.
   function automatic state_t first(input logic [3:0] l);
      state_t s;
      if (l[0])      s = S_PP0;
      else if (l[1]) s = S_PP1;
      else if (l[2]) s = S_PP2;
      else if (l[3]) s = S_PP3;
      else           s = S_DONE;
      return s;
   endfunction

   function automatic logic [3:0] nib_m(input state_t s,
                                        input logic [7:0] x);
      logic [3:0] n;
      unique case (s)
         S_PP0, S_PP2: n = x[3:0];
         S_PP1, S_PP3: n = x[7:4];
         default:      n = 4'd0;
      endcase
      return n;
   endfunction

   function automatic logic [3:0] nib_q(input state_t s,
                                        input logic [7:0] y);
      logic [3:0] n;
      unique case (s)
         S_PP0, S_PP1: n = y[3:0];
         S_PP2, S_PP3: n = y[7:4];
         default:      n = 4'd0;
      endcase
      return n;
   endfunction

   assign in_ready = (r_state == S_IDLE)
                   | ((r_state == S_DONE) & out_ready);
   assign w_accept   = in_valid & in_ready;
   assign w_live_cur = live(r_a, r_b);

   always_comb begin
      w_pp = 16'd0;
      unique case (r_state)
         S_PP0:        w_pp = {8'd0, mul_p};
         S_PP1, S_PP2: w_pp = {4'd0, mul_p, 4'd0};
         S_PP3:        w_pp = {mul_p, 8'd0};
         default:      w_pp = 16'd0;
      endcase
   end

   always_comb begin
      w_nxt     = r_state;
      w_nxt_a   = r_a;
      w_nxt_b   = r_b;
      w_nxt_acc = r_acc;
      if (w_accept) begin
         w_nxt_a   = a;
         w_nxt_b   = b;
         w_nxt_acc = 16'd0;
         w_nxt     = first(live(a, b));
      end else begin
         unique case (r_state)
            S_PP0: begin
               w_nxt_acc = r_acc + w_pp;
               w_nxt     = first(w_live_cur & 4'b1110);
            end
            S_PP1: begin
               w_nxt_acc = r_acc + w_pp;
               w_nxt     = first(w_live_cur & 4'b1100);
            end
            S_PP2: begin
               w_nxt_acc = r_acc + w_pp;
               w_nxt     = first(w_live_cur & 4'b1000);
            end
            S_PP3: begin
               w_nxt_acc = r_acc + w_pp;
               w_nxt     = S_DONE;
            end
            S_DONE: begin
               if (out_ready) w_nxt = S_IDLE;
            end
            default: w_nxt = r_state;
         endcase
      end
   end

   // Outputs are registered from the next-state values so they line up
   // with the state they describe.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_a       <= 8'd0;
         r_b       <= 8'd0;
         r_acc     <= 16'd0;
         out_valid <= 1'b0;
         product   <= 16'd0;
         busy      <= 1'b0;
         mul_m     <= 4'd0;
         mul_q     <= 4'd0;
      end else begin
         r_state   <= w_nxt;
         r_a       <= w_nxt_a;
         r_b       <= w_nxt_b;
         r_acc     <= w_nxt_acc;
         out_valid <= (w_nxt == S_DONE);
         product   <= (w_nxt == S_DONE) ? w_nxt_acc : 16'd0;
         busy      <= (w_nxt == S_PP0) | (w_nxt == S_PP1)
                    | (w_nxt == S_PP2) | (w_nxt == S_PP3);
         mul_m     <= nib_m(w_nxt, w_nxt_a);
         mul_q     <= nib_q(w_nxt, w_nxt_b);
      end
   end

endmodule
